compute_unit_pipe: RTL and testbench
====================================

# compute_unit_pipe

Parametrised, two-stage pipelined register-file ALU; successor to the 8-bit single-cycle compute unit. It decodes one instruction per cycle from a valid/ready input stream, reads operands from an internal register file with forwarding, and executes and writes back. The result, target id and status flags are presented on a valid/ready output stream. It sits between the instruction source (pin/IO decoder) and the display/output driver.

## Interface
- DATA_W, 8, operand/result width (≥4)
- NUM_REGS, 16, register-file depth (power of two, ≥2); RID_W = clog2(NUM_REGS)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted when in_valid & in_ready at rising edge
- in_op  in  4  opcode
- in_tgt / in_src0 / in_src1  in  RID_W each  target / source register ids
- in_imm  in  DATA_W  immediate (LOAD only)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  result value
- out_tgt  out  RID_W  target id of result
- out_zero / out_carry / out_err  out  1 each  status flags

## Operation
- Opcodes: 0 NOP; 1 LOAD tgt←imm; 2 ADD tgt←s0+s1; 3 SUB tgt←s0−s1; 4 AND; 5 OR; 6 NOT tgt←~s0; 7 XOR; 8 SHL tgt←s0<<s1; 9 SHR tgt←s0>>s1 (logical); A MOV tgt←s0; B–F illegal.
- s0/s1 = register values at src ids, not ids.
- Arithmetic modulo 2^DATA_W. ADD: carry = bit DATA_W of sum. SUB: carry = borrow (1 iff s0<s1 unsigned). All other ops: carry=0.
- Shifts: amount = full s1 value; amount ≥ DATA_W gives 0.
- out_zero = (out_data==0) for every op, including NOP (zero=1).
- NOP: result 0, no writeback, err=0. Illegal: result 0, no writeback, err=1, carry=0, zero=1.
- Stage D (decode reg): captures op, ids, imm and operand values on acceptance.
- Stage X: executes D contents and loads output register; register-file write of tgt happens on the same edge (opcodes 1–A only).
- Forwarding: if incoming instruction reads register written by instruction advancing out of D on the same edge, it captures the new value, not the stale file value. Forwarding applies per source independently; s0==s1==tgt is legal.
- Results leave strictly in acceptance order; none dropped or duplicated.

## Timing
- advance = !out_valid | out_ready; in_ready = !d_valid | advance (combinational, no dependency on in_valid).
- Latency: instruction accepted at edge N → out_valid=1 with its result after edge N+1 (available to consumer from edge N+1 through the edge it is taken).
- Throughput: 1 instruction/cycle while out_ready=1.
- Backpressure: out_valid & !out_ready holds out_* and D stable; in_ready=0 once D is full. Register-file write occurs only when D advances.
- out_* stable while out_valid & !out_ready.
- Reset (async, immediate on rst_n low): out_valid=0, in_ready=1 after release, out_data=0, out_tgt=0, all flags 0, D empty, all NUM_REGS entries = 0. Reset mid-stream discards in-flight instructions; no writeback from them.
- First edge after rst_n rises may accept an instruction.

## Test plan
- Reset, then back-to-back LOAD r3,0x25 / ADD r4←r3+r3 / MOV r5←r4, out_ready=1 → results 0x25, 0x4A, 0x4A on consecutive cycles (forwarding), latency 2 edges from first acceptance.
- r1=0xF0, r2=0x20: ADD r7←r1+r2 → 0x10 carry=1 zero=0; SUB r8←r1−r1 → 0x00 zero=1 carry=0; SUB r9←r2−r1 → 0x30 carry=1.
- out_ready=0, issue three LOADs (0x11,0x22,0x33) continuously → exactly two accepted, in_ready=0, out_data held at 0x11; raise out_ready → 0x11,0x22,0x33 in order, third accepted, no loss or duplication.
- Opcode 0xC with tgt=r1 after LOAD r1,0x5A → out_err=1, out_data=0; following MOV r2←r1 returns 0x5A.
- r5=0x81, r6=1: SHL → 0x02, SHR → 0x40; r6=9: SHL → 0x00 zero=1; NOT r5 → 0x7E.
- Assert rst_n low mid-clock with two instructions in flight → out_valid falls without a clock edge; after release, MOV r0←r3 returns 0x00.

Source files
------------

// File: rtl/compute_unit_pipe.sv
// Two-stage register-file ALU: decode/operand-fetch register (D), then execute into the output register.
// Latency: result valid one edge after acceptance; 1 instruction/cycle while out_ready=1.
// Backpressure: out_valid & !out_ready holds out_* and D; in_ready drops once D is full.
module compute_unit_pipe #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 16,
    localparam int RID_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [RID_W-1:0]  in_tgt,
    input  logic [RID_W-1:0]  in_src0,
    input  logic [RID_W-1:0]  in_src1,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RID_W-1:0]  out_tgt,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_err
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_MOV = 4'hA;

    localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic              d_valid;
    logic [3:0]        d_op;
    logic [RID_W-1:0]  d_tgt;
    logic [DATA_W-1:0] d_imm;
    logic [DATA_W-1:0] d_a;
    logic [DATA_W-1:0] d_b;

    logic              advance;
    logic              accept;
    logic              wb_en;
    logic              x_wr;
    logic [DATA_W-1:0] x_res;
    logic              x_carry;
    logic              x_err;
    logic [DATA_W:0]   x_sum;
    logic [DATA_W:0]   x_diff;
    logic              x_sh_big;
    logic [DATA_W-1:0] src0_val;
    logic [DATA_W-1:0] src1_val;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !d_valid || advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        x_res    = '0;
        x_carry  = 1'b0;
        x_err    = 1'b0;
        x_sum    = {1'b0, d_a} + {1'b0, d_b};
        x_diff   = {1'b0, d_a} - {1'b0, d_b};
        x_sh_big = (d_b >= SH_LIM);
        case (d_op)
            OP_NOP: x_res = '0;
            OP_LD:  x_res = d_imm;
            OP_ADD: begin
                x_res   = x_sum[DATA_W-1:0];
                x_carry = x_sum[DATA_W];
            end
            // The extra MSB of the difference is the unsigned borrow.
            OP_SUB: begin
                x_res   = x_diff[DATA_W-1:0];
                x_carry = x_diff[DATA_W];
            end
            OP_AND: x_res = d_a & d_b;
            OP_OR:  x_res = d_a | d_b;
            OP_NOT: x_res = ~d_a;
            OP_XOR: x_res = d_a ^ d_b;
            OP_SHL: x_res = x_sh_big ? '0 : (d_a << d_b);
            OP_SHR: x_res = x_sh_big ? '0 : (d_a >> d_b);
            OP_MOV: x_res = d_a;
            default: x_err = 1'b1;
        endcase
    end

    assign x_wr  = (d_op >= OP_LD) && (d_op <= OP_MOV);
    assign wb_en = advance && d_valid && x_wr;

    // An instruction accepted on the same edge as a writeback must see the new value.
    assign src0_val = (wb_en && (d_tgt == in_src0)) ? x_res : rf[in_src0];
    assign src1_val = (wb_en && (d_tgt == in_src1)) ? x_res : rf[in_src1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en) begin
            rf[d_tgt] <= x_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_op    <= '0;
            d_tgt   <= '0;
            d_imm   <= '0;
            d_a     <= '0;
            d_b     <= '0;
        end else if (accept) begin
            d_valid <= 1'b1;
            d_op    <= in_op;
            d_tgt   <= in_tgt;
            d_imm   <= in_imm;
            d_a     <= src0_val;
            d_b     <= src1_val;
        end else if (advance) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tgt   <= '0;
            out_zero  <= 1'b0;
            out_carry <= 1'b0;
            out_err   <= 1'b0;
        end else if (advance) begin
            out_valid <= d_valid;
            if (d_valid) begin
                out_data  <= x_res;
                out_tgt   <= d_tgt;
                out_zero  <= (x_res == '0);
                out_carry <= x_carry;
                out_err   <= x_err;
            end
        end
    end

endmodule

// File: tb/tb_compute_unit_pipe.sv
// Directed bench for compute_unit_pipe: driver pushes expected results on acceptance,
// a negedge monitor pops and compares each result the consumer takes.
module tb_compute_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [3:0] in_tgt;
    logic [3:0] in_src0;
    logic [3:0] in_src1;
    logic [7:0] in_imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_tgt;
    logic       out_zero;
    logic       out_carry;
    logic       out_err;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] tgt;
        logic       zero;
        logic       carry;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;

    compute_unit_pipe #(.DATA_W(8), .NUM_REGS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_tgt    (in_tgt),
        .in_src0   (in_src0),
        .in_src1   (in_src1),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tgt   (out_tgt),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result is taken at the next edge whenever out_valid & out_ready here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got data=%h tgt=%0d with nothing outstanding", out_data, out_tgt);
            end else begin
                exp_t e;
                exp_t a;
                e = exp_q.pop_front();
                a = '{data: out_data, tgt: out_tgt, zero: out_zero, carry: out_carry, err: out_err};
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL result tgt=%0d: got data=%h z=%b c=%b e=%b tgt=%0d expected data=%h z=%b c=%b e=%b tgt=%0d",
                             e.tgt, a.data, a.zero, a.carry, a.err, a.tgt, e.data, e.zero, e.carry, e.err, e.tgt);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [3:0] tgt, input logic [3:0] s0,
                        input logic [3:0] s1, input logic [7:0] imm,
                        input logic [7:0] ed, input logic ec, input logic ee);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_tgt   = tgt;
        in_src0  = s0;
        in_src1  = s1;
        in_imm   = imm;
        @(negedge clk);
        while (!in_ready && w < 60) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: op=%h tgt=%0d never accepted, in_ready=%b expected 1", op, tgt, in_ready);
            step();
        end else begin
            exp_q.push_back('{data: ed, tgt: tgt, zero: (ed == 8'h00), carry: ec, err: ee});
            n_acc++;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 60) begin
            w++;
            step();
        end
        chk("drain_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, elapsed %0t expected below 200000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_tgt    = '0;
        in_src0   = '0;
        in_src1   = '0;
        in_imm    = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tgt", out_tgt, 0);
        chk("rst_flags", {out_zero, out_carry, out_err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back forwarding chain and first-result latency.
        send(4'h1, 4'd3, 4'd0, 4'd0, 8'h25, 8'h25, 1'b0, 1'b0);
        chk("latency_not_yet", out_valid, 0);
        send(4'h2, 4'd4, 4'd3, 4'd3, 8'h00, 8'h4A, 1'b0, 1'b0);
        chk("latency_valid", out_valid, 1);
        chk("latency_data", out_data, 8'h25);
        send(4'hA, 4'd5, 4'd4, 4'd0, 8'h00, 8'h4A, 1'b0, 1'b0);
        drain();

        // Carry and borrow.
        send(4'h1, 4'd1, 4'd0, 4'd0, 8'hF0, 8'hF0, 1'b0, 1'b0);
        send(4'h1, 4'd2, 4'd0, 4'd0, 8'h20, 8'h20, 1'b0, 1'b0);
        send(4'h2, 4'd7, 4'd1, 4'd2, 8'h00, 8'h10, 1'b1, 1'b0);
        send(4'h3, 4'd8, 4'd1, 4'd1, 8'h00, 8'h00, 1'b0, 1'b0);
        send(4'h3, 4'd9, 4'd2, 4'd1, 8'h00, 8'h30, 1'b1, 1'b0);
        drain();

        // Backpressure: only two fit while the consumer stalls.
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send(4'h1, 4'd10, 4'd0, 4'd0, 8'h11, 8'h11, 1'b0, 1'b0);
                send(4'h1, 4'd11, 4'd0, 4'd0, 8'h22, 8'h22, 1'b0, 1'b0);
                send(4'h1, 4'd12, 4'd0, 4'd0, 8'h33, 8'h33, 1'b0, 1'b0);
            end
            begin
                repeat (4) step();
                chk("bp_accepted", n_acc - acc0, 2);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_out_data_held", out_data, 8'h11);
                step();
                chk("bp_out_data_still", out_data, 8'h11);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total_accepted", n_acc - acc0, 3);

        // Illegal opcode does not write back; NOP reports zero.
        send(4'h1, 4'd1, 4'd0, 4'd0, 8'h5A, 8'h5A, 1'b0, 1'b0);
        send(4'hC, 4'd1, 4'd0, 4'd0, 8'hFF, 8'h00, 1'b0, 1'b1);
        send(4'hA, 4'd2, 4'd1, 4'd0, 8'h00, 8'h5A, 1'b0, 1'b0);
        send(4'h0, 4'd3, 4'd1, 4'd1, 8'h77, 8'h00, 1'b0, 1'b0);
        drain();

        // Shifts, logic ops and shift-amount boundaries.
        send(4'h1, 4'd5, 4'd0, 4'd0, 8'h81, 8'h81, 1'b0, 1'b0);
        send(4'h1, 4'd6, 4'd0, 4'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        send(4'h8, 4'd7, 4'd5, 4'd6, 8'h00, 8'h02, 1'b0, 1'b0);
        send(4'h9, 4'd8, 4'd5, 4'd6, 8'h00, 8'h40, 1'b0, 1'b0);
        send(4'h1, 4'd6, 4'd0, 4'd0, 8'h09, 8'h09, 1'b0, 1'b0);
        send(4'h8, 4'd9, 4'd5, 4'd6, 8'h00, 8'h00, 1'b0, 1'b0);
        send(4'h6, 4'd10, 4'd5, 4'd0, 8'h00, 8'h7E, 1'b0, 1'b0);
        send(4'h4, 4'd11, 4'd5, 4'd6, 8'h00, 8'h01, 1'b0, 1'b0);
        send(4'h5, 4'd12, 4'd5, 4'd6, 8'h00, 8'h89, 1'b0, 1'b0);
        send(4'h7, 4'd13, 4'd5, 4'd6, 8'h00, 8'h88, 1'b0, 1'b0);
        send(4'h1, 4'd6, 4'd0, 4'd0, 8'h07, 8'h07, 1'b0, 1'b0);
        send(4'h9, 4'd14, 4'd5, 4'd6, 8'h00, 8'h01, 1'b0, 1'b0);
        send(4'h1, 4'd6, 4'd0, 4'd0, 8'h08, 8'h08, 1'b0, 1'b0);
        send(4'h9, 4'd15, 4'd5, 4'd6, 8'h00, 8'h00, 1'b0, 1'b0);
        send(4'h2, 4'd6, 4'd6, 4'd6, 8'h00, 8'h10, 1'b0, 1'b0);
        send(4'h2, 4'd6, 4'd6, 4'd6, 8'h00, 8'h20, 1'b0, 1'b0);
        drain();

        // Asynchronous reset with two instructions in flight.
        out_ready = 1'b0;
        send(4'h1, 4'd3, 4'd0, 4'd0, 8'h77, 8'h77, 1'b0, 1'b0);
        send(4'h2, 4'd4, 4'd3, 4'd3, 8'h00, 8'hEE, 1'b0, 1'b0);
        chk("inflight_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        send(4'hA, 4'd0, 4'd3, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        send(4'hA, 4'd1, 4'd4, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
